// File: rtl/asym_fifo_pkg.sv
// Shared helpers for the asymmetric FIFO: free-slot arithmetic and parameter legality checks.
// Combinational only; no latency or backpressure of its own.
package asym_fifo_pkg;

  function automatic int slots_free(int depth, int cnt);
    return depth - cnt;
  endfunction

  function automatic bit is_pow2(int v);
    return (v >= 1) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit depth_fits_ratio(int depth, int ratio);
    return (ratio >= 1) && ((depth % ratio) == 0);
  endfunction

endpackage

// File: rtl/asym_fifo_if.sv
// Wide-write / narrow-read FIFO bus: write and pop requests plus data, occupancy and status flags.
// Producer/consumer side uses master; the FIFO uses slave.
interface asym_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int RATIO      = 2,
  parameter int ADDR_WIDTH = 3
);
  logic                      wr;
  logic [RATIO*DATA_W-1:0]   w_data;
  logic                      rd;
  logic [DATA_W-1:0]         r_data;
  logic                      full;
  logic                      empty;
  logic                      almost_full;
  logic [ADDR_WIDTH:0]       count;
  logic                      wr_err;
  logic                      rd_err;

  modport master (
    output wr, w_data, rd,
    input  r_data, full, empty, almost_full, count, wr_err, rd_err
  );

  modport slave (
    input  wr, w_data, rd,
    output r_data, full, empty, almost_full, count, wr_err, rd_err
  );
endinterface

// File: rtl/asym_fifo_ctrl.sv
// Pointer/occupancy control: wr_ptr steps by RATIO, rd_ptr by 1; flags and errors follow one edge later.
// Backpressure: writes refused while full, pops refused while empty, each refusal pulses its error flag.
module asym_fifo_ctrl
  import asym_fifo_pkg::*;
#(
  parameter int RATIO      = 2,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  we,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  wr_err,
  output logic                  rd_err
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 2;
  localparam logic [CW-1:0]         RATIO_INC = CW'(RATIO);
  localparam logic [ADDR_WIDTH-1:0] PTR_STEP  = ADDR_WIDTH'(RATIO);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  wr_err_q;
  logic                  rd_err_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [CW-1:0]         count_next;

  // Accept decisions use only the registered occupancy, never the post-operation value.
  always_comb begin
    empty       = (count_q == '0);
    full        = slots_free(DEPTH, int'(count_q)) < RATIO;
    almost_full = int'(count_q) >= AF_LEVEL;
    wr_acc      = wr & ~full;
    rd_acc      = rd & ~empty;
    count_next  = {1'b0, count_q};
    if (wr_acc) count_next = count_next + RATIO_INC;
    if (rd_acc) count_next = count_next - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_STEP;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      count_q  <= count_next[ADDR_WIDTH:0];
      wr_err_q <= wr & full;
      rd_err_q <= rd & empty;
    end
  end

  occupancy_bounded: assert property (@(posedge clk) disable iff (reset)
    count_next <= CW'(DEPTH));

  // Reset must also suppress the storage write issued in the same cycle.
  assign we     = wr_acc & ~reset;
  assign w_addr = wr_ptr;
  assign r_addr = rd_ptr;
  assign count  = count_q;
  assign wr_err = wr_err_q;
  assign rd_err = rd_err_q;

endmodule

// File: rtl/asym_fifo.sv
// Asymmetric FIFO: RATIO*DATA_W words in, DATA_W slices out LS-slice first, first-word-fall-through, 1-cycle latency.
// Backpressure: full when fewer than RATIO slots are free; refused writes/pops flag wr_err/rd_err.
module asym_fifo
  import asym_fifo_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int RATIO      = 2,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6
) (
  input  logic           clk,
  input  logic           reset,
  asym_fifo_if.slave     bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (!is_pow2(RATIO)) begin : g_bad_ratio
    $error("asym_fifo: RATIO must be a power of 2 and at least 1");
  end
  if (!depth_fits_ratio(DEPTH, RATIO)) begin : g_bad_depth
    $error("asym_fifo: DEPTH must be a multiple of RATIO");
  end

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  we;

  asym_fifo_ctrl #(
    .RATIO      (RATIO),
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_LEVEL   (AF_LEVEL)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .wr          (bus.wr),
    .rd          (bus.rd),
    .w_addr      (w_addr),
    .r_addr      (r_addr),
    .we          (we),
    .count       (bus.count),
    .full        (bus.full),
    .empty       (bus.empty),
    .almost_full (bus.almost_full),
    .wr_err      (bus.wr_err),
    .rd_err      (bus.rd_err)
  );

  // A word never straddles the wrap since DEPTH is a multiple of RATIO.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < RATIO; i++) begin
        mem[w_addr + ADDR_WIDTH'(i)] <= bus.w_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.r_data = mem[r_addr];

endmodule
